// File: rtl/vc_rr_merge.sv
// N-input round-robin merge feeding a single registered val/rdy output (pipe-style load).
// Optional macro VC_RR_MERGE_SRC_TAG_EN prepends the winning source index to out_msg.
module vc_rr_merge #(
  parameter int p_num_reqs  = 2,
  parameter int p_msg_nbits = 8,
  localparam int c_idx_nbits = $clog2(p_num_reqs),
`ifdef VC_RR_MERGE_SRC_TAG_EN
  localparam int c_out_nbits = p_msg_nbits + c_idx_nbits
`else
  localparam int c_out_nbits = p_msg_nbits
`endif
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_num_reqs-1:0]             in_val,
  output logic [p_num_reqs-1:0]             in_rdy,
  input  logic [p_num_reqs*p_msg_nbits-1:0] in_msg,
  output logic                              out_val,
  input  logic                              out_rdy,
  output logic [c_out_nbits-1:0]           out_msg,
  input  logic                              sd,
  output logic [c_idx_nbits-1:0]           o_dbg_prio_ptr
);

  localparam logic [c_idx_nbits:0]   c_num  = (c_idx_nbits+1)'(p_num_reqs);
  localparam logic [c_idx_nbits-1:0] c_last = c_idx_nbits'(p_num_reqs - 1);

  logic                    r_out_val;
  logic [c_out_nbits-1:0]  r_out_msg;
  logic [c_idx_nbits-1:0]  r_prio_ptr;

  logic [p_msg_nbits-1:0]  w_msgs [p_num_reqs];
  logic [p_num_reqs-1:0]   w_grant;
  logic [c_idx_nbits-1:0]  w_grant_idx;
  logic                    w_any;
  logic [c_idx_nbits:0]    w_sum;
  logic [c_idx_nbits-1:0]  w_scan;
  logic                    w_ld;
  logic                    w_xfer;
  logic [c_out_nbits-1:0]  w_load_msg;
  logic [c_idx_nbits-1:0]  w_next_ptr;
  logic                    w_unused_sd;

  for (genvar g = 0; g < p_num_reqs; g++) begin : g_unpack
    assign w_msgs[g] = in_msg[g*p_msg_nbits +: p_msg_nbits];
  end

  // Scan from the priority pointer upward, wrapping at p_num_reqs rather than 2^c_idx_nbits.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_any       = 1'b0;
    w_sum       = '0;
    w_scan      = '0;
    for (int k = 0; k < p_num_reqs; k++) begin
      w_sum = {1'b0, r_prio_ptr} + (c_idx_nbits+1)'(k);
      if (w_sum >= c_num) w_sum = w_sum - c_num;
      w_scan = w_sum[c_idx_nbits-1:0];
      if (!w_any && in_val[w_scan]) begin
        w_any           = 1'b1;
        w_grant[w_scan] = 1'b1;
        w_grant_idx     = w_scan;
      end
    end
  end

  // Handshake: a beat moves on any side when val and rdy are both high at posedge clk;
  // in_rdy may depend combinationally on in_val/out_rdy, out_val never depends on out_rdy.
  assign w_ld   = ~r_out_val | out_rdy;
  assign in_rdy = w_grant & {p_num_reqs{w_ld & ~reset}};
  assign w_xfer = w_any & w_ld;

`ifdef VC_RR_MERGE_SRC_TAG_EN
  assign w_load_msg = {w_grant_idx, w_msgs[w_grant_idx]};
`else
  assign w_load_msg = w_msgs[w_grant_idx];
`endif

  assign w_next_ptr = (w_grant_idx == c_last) ? '0 : w_grant_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_val  <= 1'b0;
      r_out_msg  <= '0;
      r_prio_ptr <= '0;
    end else if (w_xfer) begin
      r_out_val  <= 1'b1;
      r_out_msg  <= w_load_msg;
      r_prio_ptr <= w_next_ptr;
    end else if (out_rdy) begin
      r_out_val  <= 1'b0;
    end
  end

  assign out_val        = r_out_val;
  assign out_msg        = r_out_msg;
  assign o_dbg_prio_ptr = r_prio_ptr;

  // Domain select is static and shared by all state; nothing in the datapath branches on it.
  assign w_unused_sd = sd;

endmodule

// File: tb/tb_vc_rr_merge.sv
// Directed bench for vc_rr_merge: N=2 and N=3 instances (plus N=4 tag instance when
// VC_RR_MERGE_SRC_TAG_EN is defined), immediate assertions at each check point.
module tb_vc_rr_merge;

`ifdef VC_RR_MERGE_SRC_TAG_EN
  localparam int c_oa = 9;
  localparam int c_ob = 10;
`else
  localparam int c_oa = 8;
  localparam int c_ob = 8;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sd = 1'b0;

  logic [1:0]      in_val_a, in_rdy_a;
  logic [15:0]     in_msg_a;
  logic            out_val_a, out_rdy_a;
  logic [c_oa-1:0] out_msg_a;
  logic            ptr_a;

  logic [2:0]      in_val_b, in_rdy_b;
  logic [23:0]     in_msg_b;
  logic            out_val_b, out_rdy_b;
  logic [c_ob-1:0] out_msg_b;
  logic [1:0]      ptr_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vc_rr_merge #(.p_num_reqs(2), .p_msg_nbits(8)) dut_a (
    .clk(clk), .reset(reset), .in_val(in_val_a), .in_rdy(in_rdy_a), .in_msg(in_msg_a),
    .out_val(out_val_a), .out_rdy(out_rdy_a), .out_msg(out_msg_a), .sd(sd),
    .o_dbg_prio_ptr(ptr_a)
  );

  vc_rr_merge #(.p_num_reqs(3), .p_msg_nbits(8)) dut_b (
    .clk(clk), .reset(reset), .in_val(in_val_b), .in_rdy(in_rdy_b), .in_msg(in_msg_b),
    .out_val(out_val_b), .out_rdy(out_rdy_b), .out_msg(out_msg_b), .sd(sd),
    .o_dbg_prio_ptr(ptr_b)
  );

`ifdef VC_RR_MERGE_SRC_TAG_EN
  logic [3:0]  in_val_c, in_rdy_c;
  logic [31:0] in_msg_c;
  logic        out_val_c;
  logic [9:0]  out_msg_c;
  logic [1:0]  ptr_c;

  vc_rr_merge #(.p_num_reqs(4), .p_msg_nbits(8)) dut_c (
    .clk(clk), .reset(reset), .in_val(in_val_c), .in_rdy(in_rdy_c), .in_msg(in_msg_c),
    .out_val(out_val_c), .out_rdy(1'b1), .out_msg(out_msg_c), .sd(sd),
    .o_dbg_prio_ptr(ptr_c)
  );
`endif

  // Expected out_msg for the N=2 and N=3 instances, including the tag when enabled.
  function automatic logic [31:0] exp_a(input logic idx, input logic [7:0] m);
`ifdef VC_RR_MERGE_SRC_TAG_EN
    exp_a = {23'd0, idx, m};
`else
    exp_a = {24'd0, m};
    if (idx) exp_a = {24'd0, m};
`endif
  endfunction

  function automatic logic [31:0] exp_b(input logic [1:0] idx, input logic [7:0] m);
`ifdef VC_RR_MERGE_SRC_TAG_EN
    exp_b = {22'd0, idx, m};
`else
    exp_b = {24'd0, m};
    if (idx != 2'd0) exp_b = {24'd0, m};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] seq_msg [4];
  logic [1:0] seq_rdy [4];
  logic [7:0] b_msg   [3];

  initial begin
    seq_msg = '{8'hAA, 8'hBB, 8'hAA, 8'hBB};
    seq_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    b_msg   = '{8'h10, 8'h11, 8'h12};

    in_val_a = 2'b11; in_msg_a = 16'hBBAA; out_rdy_a = 1'b1;
    in_val_b = 3'b000; in_msg_b = '0; out_rdy_b = 1'b1;
`ifdef VC_RR_MERGE_SRC_TAG_EN
    in_val_c = 4'b0000; in_msg_c = '0;
`endif

    // Reset: in_rdy gated even with requests pending.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_rdy_a", 32'(in_rdy_a), 32'h0);
    chk("rst_out_val_a", 32'(out_val_a), 32'h0);
    in_val_a = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle_out_val_a", 32'(out_val_a), 32'h0);
    chk("idle_out_msg_a", 32'(out_msg_a), 32'h0);
    chk("idle_in_rdy_a", 32'(in_rdy_a), 32'h0);
    chk("idle_ptr_a", 32'(ptr_a), 32'h0);
    chk("idle_out_val_b", 32'(out_val_b), 32'h0);
    chk("idle_ptr_b", 32'(ptr_b), 32'h0);

    // N=2 both valid: strict alternation at full rate.
    in_val_a = 2'b11; in_msg_a = 16'hBBAA; out_rdy_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_in_rdy", 32'(in_rdy_a), 32'(seq_rdy[i]));
      after_pos();
      chk("alt_out_val", 32'(out_val_a), 32'h1);
      chk("alt_out_msg", 32'(out_msg_a), exp_a(1'(i % 2), seq_msg[i]));
      @(negedge clk);
    end
    chk("alt_ptr_end", 32'(ptr_a), 32'h0);

    // Load 0x5A, then block the output with both inputs valid.
    in_val_a = 2'b01; in_msg_a = 16'h005A;
    after_pos();
    chk("ld5a_out_msg", 32'(out_msg_a), exp_a(1'b0, 8'h5A));
    chk("ld5a_ptr", 32'(ptr_a), 32'h1);
    @(negedge clk);
    in_val_a = 2'b11; in_msg_a = 16'h2211; out_rdy_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hold_in_rdy", 32'(in_rdy_a), 32'h0);
      after_pos();
      chk("hold_out_val", 32'(out_val_a), 32'h1);
      chk("hold_out_msg", 32'(out_msg_a), exp_a(1'b0, 8'h5A));
      chk("hold_ptr", 32'(ptr_a), 32'h1);
      @(negedge clk);
    end
    out_rdy_a = 1'b1;
    #1;
    chk("unblock_in_rdy", 32'(in_rdy_a), 32'h2);
    after_pos();
    chk("unblock_out_msg", 32'(out_msg_a), exp_a(1'b1, 8'h22));
    chk("unblock_ptr", 32'(ptr_a), 32'h0);
    @(negedge clk);
    in_val_a = 2'b00; in_msg_a = 16'hEEEE;
    after_pos();
    chk("drain_out_val", 32'(out_val_a), 32'h0);
    chk("drain_out_msg_hold", 32'(out_msg_a), exp_a(1'b1, 8'h22));
    chk("idle_ptr_hold", 32'(ptr_a), 32'h0);

    // N=3, only input 2 valid: back-to-back, pointer wraps to 0 each time.
    @(negedge clk);
    in_val_b = 3'b100;
    for (int i = 0; i < 3; i++) begin
      in_msg_b = {b_msg[i], 8'hEE, 8'hEE};
      #1;
      chk("b_in_rdy", 32'(in_rdy_b), 32'h4);
      after_pos();
      chk("b_out_val", 32'(out_val_b), 32'h1);
      chk("b_out_msg", 32'(out_msg_b), exp_b(2'd2, b_msg[i]));
      chk("b_ptr_wrap", 32'(ptr_b), 32'h0);
      @(negedge clk);
    end
    // Pointer starts at 0; input 1 beats input 2, then pointer is 2 so input 2 wins next.
    in_val_b = 3'b110; in_msg_b = 24'h3C4D00;
    #1;
    chk("b_scan_in_rdy", 32'(in_rdy_b), 32'h2);
    after_pos();
    chk("b_scan_msg", 32'(out_msg_b), exp_b(2'd1, 8'h4D));
    chk("b_scan_ptr", 32'(ptr_b), 32'h2);
    @(negedge clk);
    #1;
    chk("b_scan2_in_rdy", 32'(in_rdy_b), 32'h4);
    @(negedge clk);
    in_val_b = 3'b000;

    // Asynchronous reset while holding a message.
    in_val_a = 2'b01; in_msg_a = 16'h0033; out_rdy_a = 1'b0;
    after_pos();
    chk("pre_rst_out_val", 32'(out_val_a), 32'h1);
    chk("pre_rst_ptr", 32'(ptr_a), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_out_val", 32'(out_val_a), 32'h0);
    chk("async_rst_ptr", 32'(ptr_a), 32'h0);
    chk("async_rst_in_rdy", 32'(in_rdy_a), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    in_val_a = 2'b11; in_msg_a = 16'hBBAA; out_rdy_a = 1'b1;
    #1;
    chk("post_rst_in_rdy", 32'(in_rdy_a), 32'h1);
    after_pos();
    chk("post_rst_out_msg", 32'(out_msg_a), exp_a(1'b0, 8'hAA));
    @(negedge clk);
    in_val_a = 2'b00;

`ifdef VC_RR_MERGE_SRC_TAG_EN
    in_val_c = 4'b1000; in_msg_c = 32'h7E000000;
    after_pos();
    chk("tag_out_val", 32'(out_val_c), 32'h1);
    chk("tag_out_msg", 32'(out_msg_c), 32'h37E);
    @(negedge clk);
    in_val_c = 4'b0000;
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
